acc_req_buffer: RTL and testbench

Elastic request buffer between an accelerator request source (CVA6 dispatch or the trace-driven dispatcher) and Ara. It queues `accelerator_req_t` requests in a DEPTH-entry FIFO and forwards them to Ara. It caps in-flight instructions at MAX_OUTSTANDING and tracks one response per dispatched request. It supports a drain/flush sequence that reports when all issued instructions have completed.

---
 rtl/acc_req_buffer.sv | 138 +++++++++++++
 tb/tb_acc_req_buffer.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/acc_req_buffer.sv
// Elastic request buffer between an accelerator request source and Ara, with an outstanding cap
// and a drain/flush handshake. Optional stall statistics enabled by ACC_REQ_BUFFER_STATS_EN.
module acc_req_buffer #(
   parameter int unsigned DEPTH           = 4,
   parameter int unsigned MAX_OUTSTANDING = 8,
   parameter type         accelerator_req_t  = logic [31:0],
   parameter type         accelerator_resp_t = logic [31:0]
) (
   input  logic                                     clk_i,
   input  logic                                     rst_ni,
   input  accelerator_req_t                         acc_req_i,
   input  logic                                     acc_req_valid_i,
   output logic                                     acc_req_ready_o,
   output accelerator_req_t                         acc_req_o,
   output logic                                     acc_req_valid_o,
   input  logic                                     acc_req_ready_i,
   input  accelerator_resp_t                        acc_resp_i,
   input  logic                                     acc_resp_valid_i,
   output logic                                     acc_resp_ready_o,
   output accelerator_resp_t                        acc_resp_o,
   output logic                                     acc_resp_valid_o,
   input  logic                                     flush_i,
   output logic                                     flush_done_o,
   output logic [$clog2(MAX_OUTSTANDING+1)-1:0]     outstanding_o,
   output logic                                     idle_o,
   output logic                                     error_o,
   output logic [31:0]                              stall_cycles_o
);

   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned CntW = $clog2(DEPTH + 1);
   localparam int unsigned OutW = $clog2(MAX_OUTSTANDING + 1);
   localparam logic [CntW-1:0] DepthC = CntW'(DEPTH);
   localparam logic [PtrW-1:0] LastPtr = PtrW'(DEPTH - 1);
   localparam logic [OutW-1:0] MaxC = OutW'(MAX_OUTSTANDING);

   typedef enum logic [1:0] {StRun, StDrain, StDone} state_e;

   accelerator_req_t  mem_q [DEPTH];
   logic [PtrW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic [OutW-1:0]   out_q, out_d;
   state_e            state_q, state_d;
   logic              err_q, err_d;
   accelerator_resp_t resp_q;
   logic              resp_vld_q;
   logic              push, pop;

   assign acc_req_ready_o  = (cnt_q < DepthC) && (state_q == StRun);
   assign acc_req_valid_o  = (cnt_q != '0) && (out_q < MaxC);
   assign acc_req_o        = (cnt_q != '0) ? mem_q[rptr_q] : '0;
   assign push             = acc_req_valid_i && acc_req_ready_o;
   assign pop              = acc_req_valid_o && acc_req_ready_i;
   assign acc_resp_ready_o = 1'b1;
   assign acc_resp_o       = resp_q;
   assign acc_resp_valid_o = resp_vld_q;
   assign flush_done_o     = (state_q == StDone);
   assign outstanding_o    = out_q;
   assign idle_o           = (cnt_q == '0) && (out_q == '0);
   assign error_o          = err_q;

   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      cnt_d   = cnt_q;
      out_d   = out_q;
      err_d   = err_q;
      state_d = state_q;
      if (push) wptr_d = (wptr_q == LastPtr) ? '0 : wptr_q + 1'b1;
      if (pop)  rptr_d = (rptr_q == LastPtr) ? '0 : rptr_q + 1'b1;
      case ({push, pop})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: ;
      endcase
      // A response coinciding with a pop cancels out, even at zero outstanding.
      case ({pop, acc_resp_valid_i})
         2'b10:   out_d = out_q + 1'b1;
         2'b01: begin
            if (out_q == '0) err_d = 1'b1;
            else             out_d = out_q - 1'b1;
         end
         default: ;
      endcase
      // Drain completion looks at next-cycle counts so DONE follows the last response directly.
      case (state_q)
         StRun:   if (flush_i) state_d = StDrain;
         StDrain: if ((cnt_d == '0) && (out_d == '0)) state_d = StDone;
         StDone:  if (!flush_i) state_d = StRun;
         default: state_d = StRun;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wptr_q     <= '0;
         rptr_q     <= '0;
         cnt_q      <= '0;
         out_q      <= '0;
         err_q      <= 1'b0;
         state_q    <= StRun;
         resp_q     <= '0;
         resp_vld_q <= 1'b0;
      end else begin
         wptr_q     <= wptr_d;
         rptr_q     <= rptr_d;
         cnt_q      <= cnt_d;
         out_q      <= out_d;
         err_q      <= err_d;
         state_q    <= state_d;
         resp_vld_q <= acc_resp_valid_i;
         if (acc_resp_valid_i) resp_q <= acc_resp_i;
      end
   end

   // Storage is deliberately left unreset; occupancy masks stale entries.
   always_ff @(posedge clk_i) begin
      if (push) mem_q[wptr_q] <= acc_req_i;
   end

`ifdef ACC_REQ_BUFFER_STATS_EN
   logic [31:0] stall_q;
   logic        stall_inc;

   assign stall_inc = (acc_req_valid_o && !acc_req_ready_i) ||
                      ((cnt_q != '0) && (out_q == MaxC));

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)                          stall_q <= '0;
      else if (stall_inc && (stall_q != '1)) stall_q <= stall_q + 1'b1;
   end

   assign stall_cycles_o = stall_q;
`else
   assign stall_cycles_o = '0;
`endif

endmodule

// File: tb/tb_acc_req_buffer.sv
// Self-checking bench for acc_req_buffer: queue-based reference model compared every cycle,
// directed scenarios pinned by literal expectations, then randomized traffic.
module tb_acc_req_buffer;

   localparam int Depth = 4;
   localparam int MaxOut = 3;

   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   logic [31:0] acc_req_i = '0;
   logic        acc_req_valid_i = 1'b0;
   logic        acc_req_ready_o;
   logic [31:0] acc_req_o;
   logic        acc_req_valid_o;
   logic        acc_req_ready_i = 1'b0;
   logic [31:0] acc_resp_i = '0;
   logic        acc_resp_valid_i = 1'b0;
   logic        acc_resp_ready_o;
   logic [31:0] acc_resp_o;
   logic        acc_resp_valid_o;
   logic        flush_i = 1'b0;
   logic        flush_done_o;
   logic [1:0]  outstanding_o;
   logic        idle_o;
   logic        error_o;
   logic [31:0] stall_cycles_o;

   int checks = 0;
   int errors = 0;

   // Reference model state
   logic [31:0] mq[$];
   int          mout;
   int          mst;   // 0 run, 1 drain, 2 done
   bit          merr;
   logic [31:0] mresp;
   bit          mrv;
   logic [31:0] mstall;
   logic [31:0] sent[$];

   acc_req_buffer #(
      .DEPTH             (Depth),
      .MAX_OUTSTANDING   (MaxOut),
      .accelerator_req_t (logic [31:0]),
      .accelerator_resp_t(logic [31:0])
   ) dut (
      .clk_i           (clk_i),
      .rst_ni          (rst_ni),
      .acc_req_i       (acc_req_i),
      .acc_req_valid_i (acc_req_valid_i),
      .acc_req_ready_o (acc_req_ready_o),
      .acc_req_o       (acc_req_o),
      .acc_req_valid_o (acc_req_valid_o),
      .acc_req_ready_i (acc_req_ready_i),
      .acc_resp_i      (acc_resp_i),
      .acc_resp_valid_i(acc_resp_valid_i),
      .acc_resp_ready_o(acc_resp_ready_o),
      .acc_resp_o      (acc_resp_o),
      .acc_resp_valid_o(acc_resp_valid_o),
      .flush_i         (flush_i),
      .flush_done_o    (flush_done_o),
      .outstanding_o   (outstanding_o),
      .idle_o          (idle_o),
      .error_o         (error_o),
      .stall_cycles_o  (stall_cycles_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      mout   = 0;
      mst    = 0;
      merr   = 0;
      mresp  = '0;
      mrv    = 0;
      mstall = '0;
   endtask

   function automatic bit m_rdy();
      return (mq.size() < Depth) && (mst == 0);
   endfunction

   function automatic bit m_vld();
      return (mq.size() > 0) && (mout < MaxOut);
   endfunction

   task automatic compare_all();
      logic [31:0] ereq;
      logic [31:0] est;
      ereq = (mq.size() > 0) ? mq[0] : 32'h0;
`ifdef ACC_REQ_BUFFER_STATS_EN
      est = mstall;
`else
      est = 32'h0;
`endif
      chk("req_ready_o", acc_req_ready_o, m_rdy());
      chk("req_valid_o", acc_req_valid_o, m_vld());
      chk("req_o", acc_req_o, ereq);
      chk("resp_ready_o", acc_resp_ready_o, 1'b1);
      chk("resp_o", acc_resp_o, mresp);
      chk("resp_valid_o", acc_resp_valid_o, mrv);
      chk("flush_done_o", flush_done_o, mst == 2);
      chk("outstanding_o", outstanding_o, mout);
      chk("idle_o", idle_o, (mq.size() == 0) && (mout == 0));
      chk("error_o", error_o, merr);
      chk("stall_cycles_o", stall_cycles_o, est);
   endtask

   // Called at a negedge: check outputs, drive inputs, advance the model across one posedge.
   task automatic cycle(input bit vld, input logic [31:0] req, input bit rdy, input bit rvld,
                        input logic [31:0] rdata, input bit fl);
      bit push, pop, stall;
      compare_all();
      acc_req_valid_i  = vld;
      acc_req_i        = req;
      acc_req_ready_i  = rdy;
      acc_resp_valid_i = rvld;
      acc_resp_i       = rdata;
      flush_i          = fl;
      #1;
      push  = vld && m_rdy();
      pop   = m_vld() && rdy;
      stall = (m_vld() && !rdy) || ((mq.size() > 0) && (mout == MaxOut));
      if (pop && acc_req_valid_o) sent.push_back(acc_req_o);
      if (stall && mstall != 32'hFFFF_FFFF) mstall = mstall + 1;
      if (pop) void'(mq.pop_front());
      if (push) mq.push_back(req);
      if (pop && !rvld) mout++;
      else if (!pop && rvld) begin
         if (mout == 0) merr = 1;
         else mout--;
      end
      if (rvld) mresp = rdata;
      mrv = rvld;
      case (mst)
         0: if (fl) mst = 1;
         1: if (mq.size() == 0 && mout == 0) mst = 2;
         default: if (!fl) mst = 0;
      endcase
      @(negedge clk_i);
   endtask

   task automatic idle_cycle(input bit rdy);
      cycle(1'b0, 32'h0, rdy, 1'b0, 32'h0, 1'b0);
   endtask

   task automatic resp_cycle(input logic [31:0] rdata, input bit fl);
      cycle(1'b0, 32'h0, 1'b1, 1'b1, rdata, fl);
   endtask

   initial begin
      bit fl_r;
      model_reset();
      @(negedge clk_i);
      @(negedge clk_i);
      rst_ni = 1'b1;

      // Reset state
      chk("rst ready", acc_req_ready_o, 1'b1);
      chk("rst valid", acc_req_valid_o, 1'b0);
      chk("rst idle", idle_o, 1'b1);
      chk("rst flush_done", flush_done_o, 1'b0);
      chk("rst outstanding", outstanding_o, 0);
      chk("rst error", error_o, 1'b0);

      // Stall counter: one entry held for 10 cycles without Ara ready
      cycle(1'b1, 32'h5A5A, 1'b0, 1'b0, 32'h0, 1'b0);
      for (int i = 0; i < 10; i++) idle_cycle(1'b0);
`ifdef ACC_REQ_BUFFER_STATS_EN
      chk("stall lit", stall_cycles_o, 32'd10);
`else
      chk("stall lit", stall_cycles_o, 32'd0);
`endif
      idle_cycle(1'b1);
      resp_cycle(32'h1, 1'b0);
      sent.delete();

      // Basic flow
      cycle(1'b1, 32'hA, 1'b1, 1'b0, 32'h0, 1'b0);
      chk("basic A head", acc_req_o, 32'hA);
      chk("basic A valid", acc_req_valid_o, 1'b1);
      cycle(1'b1, 32'hB, 1'b1, 1'b0, 32'h0, 1'b0);
      cycle(1'b1, 32'hC, 1'b1, 1'b0, 32'h0, 1'b0);
      chk("basic C head", acc_req_o, 32'hC);
      idle_cycle(1'b1);
      chk("basic outstanding 3", outstanding_o, 2'd3);
      chk("basic order", {sent[0], sent[1], sent[2]}, {32'hA, 32'hB, 32'hC});
      resp_cycle(32'hDEAD, 1'b0);
      chk("basic resp_valid", acc_resp_valid_o, 1'b1);
      chk("basic resp data", acc_resp_o, 32'hDEAD);
      resp_cycle(32'h2, 1'b0);
      resp_cycle(32'h3, 1'b0);
      chk("basic idle", idle_o, 1'b1);
      sent.delete();

      // Full / backpressure with pointer wrap
      for (int i = 1; i <= 4; i++) cycle(1'b1, 32'h100 + i, 1'b0, 1'b0, 32'h0, 1'b0);
      chk("full ready low", acc_req_ready_o, 1'b0);
      cycle(1'b1, 32'h105, 1'b0, 1'b0, 32'h0, 1'b0);
      chk("full still low", acc_req_ready_o, 1'b0);
      for (int i = 0; i < 8; i++) begin
         bit pending;
         pending = !(mq.size() > 0 && mq[mq.size()-1] == 32'h105) && (sent.size() < 5);
         cycle(pending, 32'h105, 1'b1, mout > 0, 32'h77, 1'b0);
      end
      chk("full count", sent.size(), 5);
      chk("full order", {sent[0], sent[1], sent[2], sent[3], sent[4]},
          {32'h101, 32'h102, 32'h103, 32'h104, 32'h105});
      while (mout > 0) resp_cycle(32'h8, 1'b0);
      sent.delete();

      // Outstanding cap
      for (int i = 0; i < 4; i++) cycle(1'b1, 32'h200 + i, 1'b0, 1'b0, 32'h0, 1'b0);
      for (int i = 0; i < 5; i++) idle_cycle(1'b1);
      chk("cap dispatched", sent.size(), 3);
      chk("cap valid low", acc_req_valid_o, 1'b0);
      resp_cycle(32'h9, 1'b0);
      for (int i = 0; i < 3; i++) idle_cycle(1'b1);
      chk("cap one more", sent.size(), 4);
      chk("cap outstanding", outstanding_o, 2'd3);
      while (mout > 0) resp_cycle(32'hA0, 1'b0);

      // Flush with 2 queued and 1 outstanding
      cycle(1'b1, 32'h300, 1'b0, 1'b0, 32'h0, 1'b0);
      idle_cycle(1'b1);
      cycle(1'b1, 32'h301, 1'b0, 1'b0, 32'h0, 1'b0);
      cycle(1'b1, 32'h302, 1'b0, 1'b0, 32'h0, 1'b0);
      cycle(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
      chk("flush ready low", acc_req_ready_o, 1'b0);
      cycle(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);
      cycle(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);
      chk("flush outstanding 3", outstanding_o, 2'd3);
      resp_cycle(32'h1, 1'b1);
      resp_cycle(32'h2, 1'b1);
      chk("flush not done", flush_done_o, 1'b0);
      resp_cycle(32'h3, 1'b1);
      chk("flush done", flush_done_o, 1'b1);
      cycle(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);
      chk("flush stays done", flush_done_o, 1'b1);
      idle_cycle(1'b1);
      chk("flush back to run", acc_req_ready_o, 1'b1);
      chk("flush done cleared", flush_done_o, 1'b0);

      // Spurious response
      resp_cycle(32'hBAD, 1'b0);
      chk("spurious error", error_o, 1'b1);
      chk("spurious outstanding", outstanding_o, 2'd0);
      idle_cycle(1'b1);
      chk("error sticky", error_o, 1'b1);

      // Randomized traffic
      fl_r = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(39) == 0) fl_r = !fl_r;
         cycle($urandom_range(3) != 0, $urandom, $urandom_range(2) != 0,
               (mout > 0) ? bit'($urandom_range(1)) : ($urandom_range(49) == 0),
               $urandom, fl_r);
      end

      // Asynchronous reset mid-operation
      for (int i = 0; i < 3; i++) cycle(1'b1, 32'h400 + i, 1'b0, 1'b0, 32'h0, 1'b0);
      rst_ni = 1'b0;
      #1;
      chk("async rst valid", acc_req_valid_o, 1'b0);
      chk("async rst idle", idle_o, 1'b1);
      chk("async rst error", error_o, 1'b0);
      chk("async rst stall", stall_cycles_o, 32'd0);
      model_reset();
      @(negedge clk_i);
      rst_ni = 1'b1;
      for (int i = 0; i < 200; i++)
         cycle($urandom_range(1), $urandom, $urandom_range(1),
               (mout > 0) ? bit'($urandom_range(1)) : 1'b0, $urandom, 1'b0);
      compare_all();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
